// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use stall, branch flush and a scoreboard
// for a fixed-latency pipelined multi-cycle unit. Optional perf counters under HAZ_PERF_CNT_EN.
module hazard_scoreboard_unit #(
  parameter int unsigned AW         = 5,
  parameter int unsigned NUM_RS     = 2,
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RS*AW-1:0]   rs_d,
  input  logic [AW-1:0]          rd_d,
  input  logic                   regwrite_d,
  input  logic                   mc_op_d,
  input  logic [NUM_RS*AW-1:0]   rs_e,
  input  logic [AW-1:0]          rd_e,
  input  logic                   load_e,
  input  logic                   mc_issue_e,
  input  logic                   pcsrc_e,
  input  logic [AW-1:0]          rd_m,
  input  logic                   regwrite_m,
  input  logic [AW-1:0]          rd_w,
  input  logic                   regwrite_w,
  output logic [NUM_RS*2-1:0]    forward_e,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic                   mc_wb_valid,
  output logic [AW-1:0]          mc_wb_rd,
  output logic                   mc_busy,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
);

  localparam int unsigned NumRegs = 2 ** AW;

  logic [NumRegs-1:0]    pendingQ, pendingD, pendEff;
  logic [MC_LATENCY-1:0] mcValidQ;
  logic [AW-1:0]         mcRdQ [MC_LATENCY];
  logic                  wbLast;
  logic                  lwStall, sbStall, anyStall;
  logic [AW-1:0]         rsCur, rsFwd;

  assign mc_wb_valid = mcValidQ[MC_LATENCY-1];
  assign mc_wb_rd    = mc_wb_valid ? mcRdQ[MC_LATENCY-1] : '0;
  assign mc_busy     = |mcValidQ;

  // A write-back only retires the register if no younger in-flight op targets it.
  always_comb begin
    wbLast = mcValidQ[MC_LATENCY-1];
    for (int unsigned s = 0; s < MC_LATENCY - 1; s++) begin
      if (mcValidQ[s] && (mcRdQ[s] == mcRdQ[MC_LATENCY-1])) wbLast = 1'b0;
    end
  end

  always_comb begin
    pendEff  = pendingQ;
    pendingD = pendingQ;
    if (wbLast) begin
      pendEff[mcRdQ[MC_LATENCY-1]]  = 1'b0;
      pendingD[mcRdQ[MC_LATENCY-1]] = 1'b0;
    end
    // Set after clear: a same-cycle issue to the retiring reg is younger.
    if (mc_issue_e && (rd_e != '0)) pendingD[rd_e] = 1'b1;
  end

  always_comb begin
    lwStall = 1'b0;
    sbStall = 1'b0;
    rsCur   = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      rsCur = rs_d[i*AW +: AW];
      if (load_e && (rd_e != '0) && (rd_e == rsCur)) lwStall = 1'b1;
      if ((rsCur != '0) && pendEff[rsCur]) sbStall = 1'b1;
      if (mc_op_d && mc_issue_e && (rd_e != '0) && (rd_e == rsCur)) sbStall = 1'b1;
    end
    if (regwrite_d && (rd_d != '0) && pendEff[rd_d]) sbStall = 1'b1;
  end

  assign anyStall = lwStall | sbStall;
  assign stall_d  = anyStall;
  assign stall_f  = anyStall & ~pcsrc_e;
  assign flush_d  = pcsrc_e;
  assign flush_e  = anyStall | pcsrc_e;

  always_comb begin
    forward_e = '0;
    rsFwd     = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      rsFwd = rs_e[i*AW +: AW];
      if (rsFwd == '0)                          forward_e[i*2 +: 2] = 2'b00;
      else if (regwrite_m && (rd_m == rsFwd))   forward_e[i*2 +: 2] = 2'b10;
      else if (regwrite_w && (rd_w == rsFwd))   forward_e[i*2 +: 2] = 2'b01;
      else                                      forward_e[i*2 +: 2] = 2'b00;
    end
  end

  // Issue is never squashed by pcsrc_e: ops in E are older than the branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pendingQ <= '0;
      mcValidQ <= '0;
      for (int unsigned s = 0; s < MC_LATENCY; s++) mcRdQ[s] <= '0;
    end else begin
      pendingQ <= pendingD;
      mcValidQ <= {mcValidQ[MC_LATENCY-2:0], mc_issue_e};
      mcRdQ[0] <= rd_e;
      for (int unsigned s = 1; s < MC_LATENCY; s++) mcRdQ[s] <= mcRdQ[s-1];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCntQ, flushCntQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (stall_d) stallCntQ <= stallCntQ + 32'd1;
      if (flush_d) flushCntQ <= flushCntQ + 32'd1;
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
